dcache_2way: RTL and testbench
==============================

DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameter IDX_W, default 5, meaning set-index width (sets = 2^IDX_W); tag width TAG_W = 27 - IDX_W.
REQ-002 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-003 SHALL have port clk_i  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port p1_addr_i  input  32  CPU byte address: offset [4:0], index [IDX_W+4:5], tag [31:IDX_W+5].
REQ-006 SHALL have port p1_data_i  input  32  CPU write data.
REQ-007 SHALL have ports p1_MemRead_i and p1_MemWrite_i  input  1 each  CPU request strobes; req = read OR write.
REQ-008 SHALL have port p1_data_o  output  32  read data.
REQ-009 SHALL have port p1_stall_o  output  1  CPU stall.
REQ-010 SHALL have port mem_data_i  input  256  refill line from memory.
REQ-011 SHALL have port mem_ack_i  input  1  single-cycle memory completion pulse.
REQ-012 SHALL have ports mem_data_o  output  256, mem_addr_o  output  32, mem_enable_o  output  1, mem_write_o  output  1, forming the memory request.
REQ-013 SHALL have ports acc_cnt_o and miss_cnt_o  output  CNT_W each  completed-access and miss counters.

Function
REQ-014 SHALL be 2-way set-associative, write-back, write-allocate, 256-bit lines; per set and way: valid bit, dirty bit, tag, line; one LRU bit per set.
REQ-015 SHALL hold all storage in internal arrays with combinational read and rising-edge write.
REQ-016 SHALL compute hit combinationally: hit_way = way with valid AND tag match; both ways matching is impossible by construction.
REQ-017 SHALL drive p1_stall_o = req AND NOT hit, combinationally.
REQ-018 SHALL select the word with p1_addr_i[4:2] and ignore bits [1:0]; p1_data_o = that word of the hit way when hit, else 0.
REQ-019 SHALL, on every cycle with state IDLE, p1_MemWrite_i and hit: merge p1_data_i into the selected word of the hit way and set dirty=1; other words are unchanged.
REQ-020 SHALL, on every cycle with state IDLE, req and hit: set LRU[set] to the other way and increment acc_cnt_o, wrapping modulo 2^CNT_W.
REQ-021 SHALL use states IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-022 SHALL take IDLE -> MISS when req AND NOT hit, latching the victim and incrementing miss_cnt_o. Victim = way 0 if invalid, else way 1 if invalid, else the LRU way.
REQ-023 SHALL, in MISS: go to WRITEBACK if the victim is valid and dirty, setting mem_enable_o=1 and mem_write_o=1; otherwise go to READMISS with mem_enable_o=1 and mem_write_o=0.
REQ-024 SHALL, in WRITEBACK, drive mem_addr_o = {victim tag, index, 5'b0} and mem_data_o = victim line. On mem_ack_i: go to READMISS, keep mem_enable_o=1, set mem_write_o=0.
REQ-025 SHALL, in all states other than WRITEBACK, drive mem_addr_o = {p1 tag, index, 5'b0}.
REQ-026 SHALL, in READMISS on mem_ack_i: write mem_data_i into the victim way with valid=1, dirty=0 and the new tag; set mem_enable_o=0; go to READMISSOK.
REQ-027 SHALL go READMISSOK -> IDLE unconditionally; the access then hits in READMISSOK or IDLE and stall drops. A pending write completes as a write hit in IDLE.
REQ-028 SHALL hold mem_enable_o and mem_write_o stable, and ignore mem_ack_i, outside the WRITEBACK and READMISS waits.
REQ-029 SHALL require the CPU to hold p1_* stable while p1_stall_o=1; behaviour otherwise is undefined.
REQ-030 SHALL ignore the write strobe on a cycle with no hit; no partial write occurs on a miss.

Reset
REQ-031 SHALL, on rst_i low, immediately: state=IDLE; mem_enable_o=0, mem_write_o=0; all valid, dirty and LRU bits cleared; acc_cnt_o=0, miss_cnt_o=0.
REQ-032 SHALL abort an in-flight miss on reset mid-operation with no line written; line data contents need not be cleared.

Verification
REQ-033 SHALL cover cold read miss: after reset, read 0x400 -> stall=1, mem_enable_o=1, mem_write_o=0, mem_addr_o=0x400; ack with word0=0xAAAA0001 -> stall=0 within 2 cycles, p1_data_o=0xAAAA0001, miss_cnt_o=1, acc_cnt_o=1.
REQ-034 SHALL cover way fill: fill 0x400 then 0x800 (both set 0) -> no writeback; re-read 0x400 -> stall=0 with no mem_enable_o pulse, acc_cnt_o increments.
REQ-035 SHALL cover dirty eviction: fill 0x400, write 0x404=0x12345678, fill and read 0x800, read 0xC00 -> mem_write_o=1, mem_addr_o=0x400, mem_data_o[63:32]=0x12345678; then a read request to 0xC00.
REQ-036 SHALL cover word select: line at 0x400 with word7=0xDEADBEEF -> read 0x41C returns 0xDEADBEEF the same cycle with stall=0.
REQ-037 SHALL cover reset mid-miss: rst_i low during READMISS -> mem_enable_o=0 asynchronously; a later read of 0x400 misses again and counters restart from 0.

Source files
------------

// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative write-back data cache
// LRU replacement, one outstanding miss, access/miss counters
module dcache_2way #(
  parameter int IDX_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      p1_addr_i,
  input  logic [31:0]      p1_data_i,
  input  logic             p1_MemRead_i,
  input  logic             p1_MemWrite_i,
  output logic [31:0]      p1_data_o,
  output logic             p1_stall_o,
  input  logic [255:0]     mem_data_i,
  input  logic             mem_ack_i,
  output logic [255:0]     mem_data_o,
  output logic [31:0]      mem_addr_o,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic [CNT_W-1:0] acc_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int TAG_W = 27 - IDX_W;
  localparam int SETS  = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE, MISS, WRITEBACK, READMISS, READMISSOK
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  dirty_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [255:0]     line_q  [2][SETS];
  logic             victim_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag_in;
  logic [2:0]       word;
  logic             req, hit0, hit1, hit, hit_way;
  logic             vict, vic_dirty;
  logic [255:0]     hit_line, wr_line;
  logic             idle, wr_hit, acc_hit, miss_start, fill;
  logic             mem_en_d, mem_wr_d;
  logic             unused_addr;

  assign idx         = p1_addr_i[IDX_W+4:5];
  assign tag_in      = p1_addr_i[31:IDX_W+5];
  assign word        = p1_addr_i[4:2];
  assign unused_addr = ^p1_addr_i[1:0];

  assign req     = p1_MemRead_i | p1_MemWrite_i;
  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag_in);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag_in);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  assign hit_line   = line_q[hit_way][idx];
  assign p1_data_o  = hit ? hit_line[word*32 +: 32] : '0;
  assign p1_stall_o = req & ~hit;

  // Fill invalid ways first, then replace the least recently used
  assign vict = ~valid_q[0][idx] ? 1'b0 :
                ~valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign vic_dirty = valid_q[victim_q][idx] &
                     dirty_q[victim_q][idx];

  assign idle       = (state_q == IDLE);
  assign wr_hit     = idle & p1_MemWrite_i & hit;
  assign acc_hit    = idle & req & hit;
  assign miss_start = idle & req & ~hit;
  assign fill       = (state_q == READMISS) & mem_ack_i;

  // Merge the CPU word into the hit line
  always_comb begin
    wr_line = hit_line;
    wr_line[word*32 +: 32] = p1_data_i;
  end

  // State and memory-request strobes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_enable_o <= mem_en_d;
      mem_write_o  <= mem_wr_d;
    end
  end

  // Miss sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (miss_start) state_d = MISS;
      MISS:       state_d = vic_dirty ? WRITEBACK
                                      : READMISS;
      WRITEBACK:  if (mem_ack_i) state_d = READMISS;
      READMISS:   if (mem_ack_i) state_d = READMISSOK;
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Memory request address/data and next strobe values
  always_comb begin
    mem_en_d   = mem_enable_o;
    mem_wr_d   = mem_write_o;
    mem_addr_o = {tag_in, idx, 5'b0};
    mem_data_o = line_q[victim_q][idx];
    unique case (state_q)
      MISS: begin
        mem_en_d = 1'b1;
        mem_wr_d = vic_dirty;
      end
      WRITEBACK: begin
        mem_addr_o = {tag_q[victim_q][idx], idx, 5'b0};
        if (mem_ack_i) begin
          mem_en_d = 1'b1;
          mem_wr_d = 1'b0;
        end
      end
      READMISS: if (mem_ack_i) mem_en_d = 1'b0;
      default: ;
    endcase
  end

  // Line metadata, victim latch and counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      victim_q   <= 1'b0;
      acc_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (acc_hit) begin
        lru_q[idx] <= ~hit_way;
        acc_cnt_o  <= acc_cnt_o + CNT_W'(1);
      end
      if (wr_hit)
        dirty_q[hit_way][idx] <= 1'b1;
      if (miss_start) begin
        victim_q   <= vict;
        miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
      if (fill) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  // Line data and tags; validity gates their use
  always_ff @(posedge clk_i) begin
    if (wr_hit)
      line_q[hit_way][idx] <= wr_line;
    if (fill) begin
      line_q[victim_q][idx] <= mem_data_i;
      tag_q[victim_q][idx]  <= tag_in;
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: randomized bench for dcache_2way
// flat-memory shadow plus per-set recency model
module tb_dcache_2way;

  localparam int SETS = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  p1_addr_i = '0;
  logic [31:0]  p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0;
  logic         p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  acc_cnt_o;
  logic [31:0]  miss_cnt_o;

  dcache_2way #(.IDX_W(5), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o),
    .acc_cnt_o(acc_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass = 0;
  int unsigned cyc = 0;
  always @(posedge clk_i) cyc++;

  logic [31:0] respm  [int unsigned];
  logic [31:0] shadow [int unsigned];

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } ev_t;
  ev_t evq[$];

  int          en_seen = 0;
  bit          resp_en = 1'b1;
  int          lat = 0;
  int unsigned ack_cyc = 0;
  int unsigned drop_cyc = 0;
  logic [31:0] last_data;
  logic        last_stall;

  logic [21:0] mtag   [SETS][2];
  bit          mdirty [SETS][2];
  int          mcnt   [SETS];
  int unsigned m_acc, m_miss;

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] rd_resp(input int unsigned wa);
    return respm.exists(wa) ? respm[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] rd_shadow(input int unsigned wa);
    return shadow.exists(wa) ? shadow[wa] : init_word(wa);
  endfunction

  function automatic logic [255:0] resp_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = rd_resp({a[31:5], 3'(w)});
    return l;
  endfunction

  function automatic logic [255:0] shadow_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = rd_shadow({a[31:5], 3'(w)});
    return l;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    respm[a[31:2]]  = v;
    shadow[a[31:2]] = v;
  endtask

  // Memory responder: random latency, one-cycle ack
  always @(negedge clk_i) begin
    if (mem_enable_o) en_seen++;
    if (!rst_i) begin
      mem_ack_i = 1'b0;
      lat = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (resp_en && mem_enable_o) begin
      if (lat != 0) lat--;
      else begin
        if (mem_write_o) begin
          for (int w = 0; w < 8; w++)
            respm[{mem_addr_o[31:5], 3'(w)}] = mem_data_o[w*32 +: 32];
        end else begin
          mem_data_i = resp_line(mem_addr_o);
        end
        evq.push_back('{mem_write_o, mem_addr_o, mem_data_o});
        mem_ack_i = 1'b1;
        ack_cyc = cyc;
        lat = $urandom_range(0, 3);
      end
    end
  end

  // Reset empties the cache: visible memory reverts to backing memory
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) mcnt[s] = 0;
    m_acc = 0;
    m_miss = 0;
    shadow.delete();
    foreach (respm[k]) shadow[k] = respm[k];
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
  endtask

  task automatic access(input logic [31:0] addr, input bit wr,
                        input logic [31:0] wdata);
    int s, pos, guard, nexp, k, last;
    logic [21:0] t;
    int unsigned wa;
    bit exp_miss, exp_wb, odirty;
    logic [31:0] wb_addr, exp_data;
    logic [255:0] wb_data;
    s = int'(addr[9:5]);
    t = addr[31:10];
    wa = addr[31:2];
    pos = -1;
    for (int i = 0; i < mcnt[s]; i++)
      if (mtag[s][i] == t) pos = i;
    exp_miss = (pos < 0);
    exp_wb = exp_miss && mcnt[s] == 2 && mdirty[s][1];
    wb_addr = {mtag[s][1], addr[9:5], 5'b0};
    wb_data = shadow_line(wb_addr);
    exp_data = rd_shadow(wa);
    @(negedge clk_i);
    evq.delete();
    en_seen = 0;
    p1_addr_i = addr;
    p1_data_i = wdata;
    p1_MemRead_i = !wr;
    p1_MemWrite_i = wr;
    #1;
    last_stall = p1_stall_o;
    n_checks++;
    if (p1_stall_o !== exp_miss)
      $display("FAIL stall %h: got %b want %b", addr, p1_stall_o, exp_miss);
    else n_pass++;
    guard = 0;
    while (p1_stall_o === 1'b1 && guard < 64) begin
      @(negedge clk_i);
      #1;
      guard++;
    end
    n_checks++;
    if (guard >= 64)
      $display("FAIL timeout %h: stall stuck got 1 want 0", addr);
    else n_pass++;
    drop_cyc = cyc;
    if (exp_miss) begin
      @(negedge clk_i);
      #1;
    end
    last_data = p1_data_o;
    n_checks++;
    if (p1_data_o !== exp_data || p1_stall_o !== 1'b0)
      $display("FAIL rdata %h: got %h/%b want %h/0", addr, p1_data_o, p1_stall_o, exp_data);
    else n_pass++;
    nexp = exp_miss ? (exp_wb ? 2 : 1) : 0;
    n_checks++;
    if (evq.size() != nexp)
      $display("FAIL memreqs %h: got %0d want %0d", addr, evq.size(), nexp);
    else n_pass++;
    if (evq.size() == nexp && exp_miss) begin
      k = 0;
      if (exp_wb) begin
        n_checks++;
        if (evq[0].wr !== 1'b1 || evq[0].addr !== wb_addr || evq[0].data !== wb_data)
          $display("FAIL wb %h: got %b %h want 1 %h", addr, evq[0].wr, evq[0].addr, wb_addr);
        else n_pass++;
        k = 1;
      end
      n_checks++;
      if (evq[k].wr !== 1'b0 || evq[k].addr !== {addr[31:5], 5'b0})
        $display("FAIL refill %h: got %b %h want 0 %h", addr, evq[k].wr, evq[k].addr, {addr[31:5], 5'b0});
      else n_pass++;
    end
    if (!exp_miss) begin
      n_checks++;
      if (en_seen != 0)
        $display("FAIL hit_noreq %h: got %0d want 0", addr, en_seen);
      else n_pass++;
    end
    m_acc++;
    if (exp_miss) m_miss++;
    if (wr) shadow[wa] = wdata;
    if (exp_miss) begin
      odirty = 1'b0;
      if (mcnt[s] < 2) mcnt[s]++;
      last = mcnt[s] - 1;
    end else begin
      odirty = mdirty[s][pos];
      last = pos;
    end
    for (int i = last; i > 0; i--) begin
      mtag[s][i] = mtag[s][i-1];
      mdirty[s][i] = mdirty[s][i-1];
    end
    mtag[s][0] = t;
    mdirty[s][0] = odirty | wr;
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    #1;
    n_checks++;
    if (acc_cnt_o !== m_acc || miss_cnt_o !== m_miss)
      $display("FAIL counters: got %0d/%0d want %0d/%0d", acc_cnt_o, miss_cnt_o, m_acc, m_miss);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0)
      $display("FAIL rst_mem: got %b%b want 00", mem_enable_o, mem_write_o);
    else n_pass++;
    n_checks++;
    if (acc_cnt_o !== 0 || miss_cnt_o !== 0)
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", acc_cnt_o, miss_cnt_o);
    else n_pass++;
    n_checks++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0)
      $display("FAIL rst_p1: got %b %h want 0 0", p1_stall_o, p1_data_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_miss();
    do_reset();
    poke(32'h400, 32'hAAAA0001);
    access(32'h400, 1'b0, 32'h0);
    n_checks++;
    if (last_data !== 32'hAAAA0001)
      $display("FAIL cold_data: got %h want aaaa0001", last_data);
    else n_pass++;
    n_checks++;
    if (drop_cyc - ack_cyc > 2)
      $display("FAIL cold_latency: got %0d want <=2", drop_cyc - ack_cyc);
    else n_pass++;
    n_checks++;
    if (acc_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1)
      $display("FAIL cold_cnt: got %0d/%0d want 1/1", acc_cnt_o, miss_cnt_o);
    else n_pass++;
  endtask

  task automatic test_way_fill();
    do_reset();
    access(32'h400, 1'b0, 32'h0);
    access(32'h800, 1'b0, 32'h0);
    access(32'h400, 1'b0, 32'h0);
    n_checks++;
    if (acc_cnt_o !== 32'd3 || miss_cnt_o !== 32'd2 || last_stall !== 1'b0)
      $display("FAIL wayfill: got %0d/%0d/%b want 3/2/0", acc_cnt_o, miss_cnt_o, last_stall);
    else n_pass++;
  endtask

  task automatic test_dirty_evict();
    do_reset();
    access(32'h400, 1'b0, 32'h0);
    access(32'h404, 1'b1, 32'h12345678);
    access(32'h800, 1'b0, 32'h0);
    access(32'hC00, 1'b0, 32'h0);
    n_checks++;
    if (evq.size() != 2)
      $display("FAIL evict_n: got %0d want 2", evq.size());
    else begin
      n_pass++;
      n_checks++;
      if (evq[0].wr !== 1'b1 || evq[0].addr !== 32'h400 || evq[0].data[63:32] !== 32'h12345678)
        $display("FAIL evict_wb: got %b %h %h want 1 400 12345678", evq[0].wr, evq[0].addr, evq[0].data[63:32]);
      else n_pass++;
      n_checks++;
      if (evq[1].wr !== 1'b0 || evq[1].addr !== 32'hC00)
        $display("FAIL evict_rd: got %b %h want 0 c00", evq[1].wr, evq[1].addr);
      else n_pass++;
    end
  endtask

  task automatic test_word_select();
    do_reset();
    poke(32'h41C, 32'hDEADBEEF);
    access(32'h400, 1'b0, 32'h0);
    access(32'h41E, 1'b0, 32'h0);
    n_checks++;
    if (last_data !== 32'hDEADBEEF || last_stall !== 1'b0)
      $display("FAIL wordsel: got %h/%b want deadbeef/0", last_data, last_stall);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [21:0] pool [5];
    logic [31:0] a;
    pool[0] = 22'h0;
    pool[1] = 22'h1;
    pool[2] = 22'h2;
    pool[3] = 22'h3;
    pool[4] = 22'h3FFFFF;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      a = {pool[$urandom_range(0, 4)], 5'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(a, $urandom_range(0, 9) < 4, $urandom);
    end
  endtask

  task automatic test_reset_mid_miss();
    int guard;
    resp_en = 1'b0;
    @(negedge clk_i);
    p1_addr_i = 32'h0004_0400;
    p1_MemRead_i = 1'b1;
    guard = 0;
    while (mem_enable_o !== 1'b1 && guard < 16) begin
      @(negedge clk_i);
      guard++;
    end
    n_checks++;
    if (mem_enable_o !== 1'b1)
      $display("FAIL midmiss_req: got %b want 1", mem_enable_o);
    else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0)
      $display("FAIL midmiss_en: got %b%b want 00", mem_enable_o, mem_write_o);
    else n_pass++;
    n_checks++;
    if (acc_cnt_o !== 0 || miss_cnt_o !== 0)
      $display("FAIL midmiss_cnt: got %0d/%0d want 0/0", acc_cnt_o, miss_cnt_o);
    else n_pass++;
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    rst_i = 1'b1;
    model_reset();
    resp_en = 1'b1;
    access(32'h400, 1'b0, 32'h0);
    n_checks++;
    if (last_stall !== 1'b1 || acc_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1)
      $display("FAIL midmiss_after: got %b %0d/%0d want 1 1/1", last_stall, acc_cnt_o, miss_cnt_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_way_fill();
    test_dirty_evict();
    test_word_select();
    test_random();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
